traffic_phase_ctrl: RTL and testbench

Actuated multi-phase traffic controller, the parametrised successor to the single-approach smart light. It serves NUM_PHASES conflicting approaches in round-robin order, with an internal duration counter, vehicle-actuated green extension, latched pedestrian requests with walk signals, and all-red clearance between phases. It sits between the sensor front end and the lamp drivers of an intersection.

---
 rtl/traffic_pkg.sv | 23 ++
 rtl/tlc_rr_arbiter.sv | 35 +++
 rtl/traffic_phase_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_traffic_phase_ctrl.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared types and lamp codes for the multi-phase traffic controller.
package traffic_pkg;

  typedef enum logic [1:0] {
    LIGHT_OFF    = 2'b00,
    LIGHT_RED    = 2'b01,
    LIGHT_YELLOW = 2'b10,
    LIGHT_GREEN  = 2'b11
  } light_t;

  typedef enum logic [1:0] {
    S_OFF     = 2'b00,
    S_ALL_RED = 2'b01,
    S_GREEN   = 2'b10,
    S_YELLOW  = 2'b11
  } state_t;

  localparam logic [1:0] LC_OFF    = LIGHT_OFF;
  localparam logic [1:0] LC_RED    = LIGHT_RED;
  localparam logic [1:0] LC_YELLOW = LIGHT_YELLOW;
  localparam logic [1:0] LC_GREEN  = LIGHT_GREEN;

endpackage

// File: rtl/tlc_rr_arbiter.sv
// Round-robin phase picker: scans upward from the phase after active_phase,
// wrapping, and reports whether any phase other than the active one is waiting.
module tlc_rr_arbiter #(
  parameter int NUM_PHASES = 2
) (
  input  logic [NUM_PHASES-1:0]         pending,
  input  logic [$clog2(NUM_PHASES)-1:0] active_phase,
  output logic [$clog2(NUM_PHASES)-1:0] next_phase,
  output logic                          other_pending
);

  localparam int PW = $clog2(NUM_PHASES);

  int   scan_idx;
  logic found;

  // The active phase is scanned last so it is only re-chosen when nothing else waits.
  always_comb begin
    scan_idx      = 0;
    found         = 1'b0;
    other_pending = 1'b0;
    next_phase    = PW'((int'(active_phase) + 1) % NUM_PHASES);
    for (int k = 1; k <= NUM_PHASES; k++) begin
      scan_idx = (int'(active_phase) + k) % NUM_PHASES;
      if (pending[PW'(scan_idx)]) begin
        if (k < NUM_PHASES) other_pending = 1'b1;
        if (!found) begin
          next_phase = PW'(scan_idx);
          found      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Actuated round-robin traffic controller with pedestrian walk and all-red clearance.
// Optional green flicker before yellow is enabled by defining TLC_FLICKER_EN.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_OFF     | lamps dark, idle until start
// S_ALL_RED | clearance, every approach red for RED_CLR cycles
// S_GREEN   | active_phase green; rests until conflicting demand allows exit
// S_YELLOW  | active_phase yellow for YELLOW_T cycles
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int NUM_PHASES = 2,
  parameter int TW         = 6,
  parameter int RED_CLR    = 2,
  parameter int YELLOW_T   = 3,
  parameter int GREEN_MIN  = 5,
  parameter int GREEN_MAX  = 20,
  parameter int WALK_T     = 4,
  parameter int FLK_T      = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [NUM_PHASES-1:0]         car_req,
  input  logic [NUM_PHASES-1:0]         ped_req,
  output logic [2*NUM_PHASES-1:0]       light,
  output logic [NUM_PHASES-1:0]         walk,
  output logic [$clog2(NUM_PHASES)-1:0] active_phase,
  output logic                          busy
);

  localparam int PW = $clog2(NUM_PHASES);

  localparam logic [TW-1:0] RED_LD  = TW'(RED_CLR - 1);
  localparam logic [TW-1:0] YEL_LD  = TW'(YELLOW_T - 1);
  localparam logic [TW-1:0] WALK_LD = TW'(WALK_T - 1);
  localparam logic [TW-1:0] GMIN_M1 = TW'(GREEN_MIN - 1);
  localparam logic [TW-1:0] GMAX_M1 = TW'(GREEN_MAX - 1);
  localparam logic [2*NUM_PHASES-1:0] ALL_RED_V = {NUM_PHASES{LC_RED}};

  if (NUM_PHASES < 2 || WALK_T > GREEN_MIN || GREEN_MAX >= (1 << TW) ||
      RED_CLR < 1 || YELLOW_T < 1 || WALK_T < 1 || FLK_T < 1) begin : g_param_check
    $error("traffic_phase_ctrl: inconsistent parameter set");
  end

  state_t                  state_q, state_d;
  logic [TW-1:0]           dur_q, dur_d;
  logic [TW-1:0]           green_cnt_q, green_cnt_d;
  logic [TW-1:0]           walk_cnt_q, walk_cnt_d;
  logic [NUM_PHASES-1:0]   ped_lat_q, ped_lat_d;
  logic [2*NUM_PHASES-1:0] light_q, light_d;
  logic [NUM_PHASES-1:0]   walk_q, walk_d;
  logic [PW-1:0]           active_q, active_d;
  logic                    busy_q, busy_d;
`ifdef TLC_FLICKER_EN
  localparam logic [TW-1:0] FLK_LD = TW'(FLK_T - 1);
  logic                    flk_q, flk_d;
`endif

  logic [NUM_PHASES-1:0] pending;
  logic [PW-1:0]         next_phase;
  logic                  other_pending;
  logic                  exit_ok;
  int                    act_idx;
  int                    nxt_idx;

  assign pending = car_req | ped_lat_q;
  assign act_idx = int'(active_q);
  assign nxt_idx = int'(next_phase);

  tlc_rr_arbiter #(
    .NUM_PHASES (NUM_PHASES)
  ) u_arb (
    .pending       (pending),
    .active_phase  (active_q),
    .next_phase    (next_phase),
    .other_pending (other_pending)
  );

  always_comb begin
    state_d     = state_q;
    dur_d       = dur_q;
    green_cnt_d = green_cnt_q;
    walk_cnt_d  = walk_cnt_q;
    ped_lat_d   = ped_lat_q;
    light_d     = light_q;
    walk_d      = walk_q;
    active_d    = active_q;
    busy_d      = busy_q;
    exit_ok     = 1'b0;
`ifdef TLC_FLICKER_EN
    flk_d       = flk_q;
`endif

    if (state_q != S_OFF) ped_lat_d = ped_lat_q | ped_req;

    case (state_q)
      S_OFF: begin
        light_d = {NUM_PHASES{LC_OFF}};
        walk_d  = '0;
        busy_d  = 1'b0;
        if (start) begin
          state_d  = S_ALL_RED;
          dur_d    = RED_LD;
          light_d  = ALL_RED_V;
          busy_d   = 1'b1;
          // Parking on the last phase makes the first green go to phase 0.
          active_d = PW'(NUM_PHASES - 1);
        end
      end

      S_ALL_RED: begin
        if (dur_q == '0) begin
          state_d     = S_GREEN;
          active_d    = next_phase;
          green_cnt_d = '0;
          light_d     = ALL_RED_V;
          light_d[2*nxt_idx +: 2] = LC_GREEN;
          walk_d      = '0;
          // A press landing on the entry edge is granted; the clear wins over the set.
          if (ped_lat_q[next_phase] || ped_req[next_phase]) begin
            walk_d[next_phase] = 1'b1;
            walk_cnt_d         = WALK_LD;
          end
          ped_lat_d[next_phase] = 1'b0;
        end else begin
          dur_d = dur_q - 1'b1;
        end
      end

      S_GREEN: begin
        if (walk_q != '0) begin
          if (walk_cnt_q == '0) walk_d = '0;
          else                  walk_cnt_d = walk_cnt_q - 1'b1;
        end
        if (green_cnt_q < GMAX_M1) green_cnt_d = green_cnt_q + 1'b1;
        exit_ok = other_pending && (green_cnt_q >= GMIN_M1) &&
                  (!car_req[active_q] || (green_cnt_q >= GMAX_M1));
`ifdef TLC_FLICKER_EN
        // Once committed to leaving, hold green FLK_T more cycles blinking 00/11.
        if (flk_q) begin
          if (dur_q == '0) begin
            flk_d   = 1'b0;
            state_d = S_YELLOW;
            dur_d   = YEL_LD;
            walk_d  = '0;
            light_d[2*act_idx +: 2] = LC_YELLOW;
          end else begin
            dur_d = dur_q - 1'b1;
            light_d[2*act_idx +: 2] =
              (light_q[2*act_idx +: 2] == LC_OFF) ? LC_GREEN : LC_OFF;
          end
        end else if (exit_ok) begin
          flk_d = 1'b1;
          dur_d = FLK_LD;
          light_d[2*act_idx +: 2] = LC_OFF;
        end
`else
        if (exit_ok) begin
          state_d = S_YELLOW;
          dur_d   = YEL_LD;
          walk_d  = '0;
          light_d[2*act_idx +: 2] = LC_YELLOW;
        end
`endif
      end

      S_YELLOW: begin
        if (dur_q == '0) begin
          state_d = S_ALL_RED;
          dur_d   = RED_LD;
          light_d = ALL_RED_V;
        end else begin
          dur_d = dur_q - 1'b1;
        end
      end

      default: begin
        state_d = S_OFF;
        light_d = {NUM_PHASES{LC_OFF}};
        walk_d  = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_OFF;
      dur_q       <= '0;
      green_cnt_q <= '0;
      walk_cnt_q  <= '0;
      ped_lat_q   <= '0;
      light_q     <= '0;
      walk_q      <= '0;
      active_q    <= '0;
      busy_q      <= 1'b0;
`ifdef TLC_FLICKER_EN
      flk_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      dur_q       <= dur_d;
      green_cnt_q <= green_cnt_d;
      walk_cnt_q  <= walk_cnt_d;
      ped_lat_q   <= ped_lat_d;
      light_q     <= light_d;
      walk_q      <= walk_d;
      active_q    <= active_d;
      busy_q      <= busy_d;
`ifdef TLC_FLICKER_EN
      flk_q       <= flk_d;
`endif
    end
  end

  assign light        = light_q;
  assign walk         = walk_q;
  assign active_phase = active_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl (default build, two phases): every cycle
// the stimulus queues the expected lamps/walk/phase and a monitor compares them.
module tb_traffic_phase_ctrl;

  localparam logic [3:0] OFF = 4'b0000;
  localparam logic [3:0] RR  = 4'b0101;
  localparam logic [3:0] G0  = 4'b0111;
  localparam logic [3:0] Y0  = 4'b0110;
  localparam logic [3:0] G1  = 4'b1101;
  localparam logic [3:0] Y1  = 4'b1001;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] car_req;
  logic [1:0] ped_req;
  logic [3:0] light;
  logic [1:0] walk;
  logic       active_phase;
  logic       busy;

  typedef struct {
    logic [3:0] l;
    logic [1:0] w;
    int         a;
    string      nm;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  traffic_phase_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .car_req      (car_req),
    .ped_req      (ped_req),
    .light        (light),
    .walk         (walk),
    .active_phase (active_phase),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input string fld, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s %s: got %b expected %b (t=%0t)", nm, fld, got, exp, $time);
    end
  endtask

  // Monitor: outputs are sampled mid-cycle, one queued expectation per clock.
  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      mon_e = sb_q.pop_front();
      chk(mon_e.nm, "light", light, mon_e.l);
      chk(mon_e.nm, "walk", {2'b00, walk}, {2'b00, mon_e.w});
      chk(mon_e.nm, "busy", {3'b000, busy}, {3'b000, (mon_e.l != 4'b0000)});
      if (mon_e.a >= 0) chk(mon_e.nm, "active", {3'b000, active_phase}, 4'(mon_e.a));
    end
  end

  // One clock: expectation is for the outputs right after this edge.
  task automatic cyc(input logic [3:0] el, input logic [1:0] ew, input int ea, input string nm);
    exp_t e;
    @(posedge clk);
    e.l = el; e.w = ew; e.a = ea; e.nm = nm;
    sb_q.push_back(e);
    #1;
    start   = 1'b0;
    ped_req = 2'b00;
  endtask

  task automatic cycn(input int n, input logic [3:0] el, input logic [1:0] ew, input int ea, input string nm);
    for (int i = 0; i < n; i++) cyc(el, ew, ea, nm);
  endtask

  // Hand phase 1 back to phase 0 and return to phase 1 (both via minimum greens).
  task automatic swing_back_to_g1(input string nm);
    car_req = 2'b01;
    cycn(3, Y1, 2'b00, 1, {nm, "_y1"});
    cycn(2, RR, 2'b00, -1, {nm, "_rr_a"});
    cyc(G0, 2'b00, 0, {nm, "_g0_entry"});
    car_req = 2'b10;
    cycn(4, G0, 2'b00, 0, {nm, "_g0"});
    cycn(3, Y0, 2'b00, 0, {nm, "_y0"});
    cycn(2, RR, 2'b00, -1, {nm, "_rr_b"});
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; car_req = 2'b00; ped_req = 2'b00;

    // Power-up, start, minimum green, resting green, start ignored while busy
    cycn(2, OFF, 2'b00, 0, "reset");
    reset = 1'b0;
    cyc(OFF, 2'b00, 0, "idle_off");
    start = 1'b1;
    cyc(RR, 2'b00, -1, "start_allred");
    cyc(RR, 2'b00, -1, "allred_2nd");
    cycn(5, G0, 2'b00, 0, "g0_first5");
    start = 1'b1;
    cyc(G0, 2'b00, 0, "start_ignored");
    cycn(30, G0, 2'b00, 0, "rest_green");

    // Actuated extension with both approaches demanding
    reset = 1'b1;
    cyc(OFF, 2'b00, 0, "rst_ext");
    reset = 1'b0; car_req = 2'b11; start = 1'b1;
    cycn(2, RR, 2'b00, -1, "ext_allred");
    cycn(20, G0, 2'b00, 0, "ext_g0_max");
    cycn(3, Y0, 2'b00, 0, "ext_y0");
    cycn(2, RR, 2'b00, -1, "ext_rr");
    cyc(G1, 2'b00, 1, "ext_g1");

    // Pedestrian service on phase 1, then prove the latch was consumed
    reset = 1'b1;
    cyc(OFF, 2'b00, 0, "rst_ped");
    reset = 1'b0; car_req = 2'b00; start = 1'b1;
    cycn(2, RR, 2'b00, -1, "ped_allred");
    cycn(3, G0, 2'b00, 0, "ped_g0");
    ped_req = 2'b10;
    cyc(G0, 2'b00, 0, "ped_press");
    cyc(G0, 2'b00, 0, "ped_g0_last");
    cycn(3, Y0, 2'b00, 0, "ped_y0");
    cycn(2, RR, 2'b00, -1, "ped_rr");
    cycn(4, G1, 2'b10, 1, "ped_walk");
    cycn(3, G1, 2'b00, 1, "ped_walk_done");
    swing_back_to_g1("lat1");
    cyc(G1, 2'b00, 1, "ped_latch_cleared");
    cycn(4, G1, 2'b00, 1, "g1_rest");

    // Press on the exact green-entry edge of phase 1
    car_req = 2'b01;
    cycn(3, Y1, 2'b00, 1, "sim_y1");
    cycn(2, RR, 2'b00, -1, "sim_rr_a");
    cyc(G0, 2'b00, 0, "sim_g0_entry");
    car_req = 2'b10;
    cycn(4, G0, 2'b00, 0, "sim_g0");
    cycn(3, Y0, 2'b00, 0, "sim_y0");
    cycn(2, RR, 2'b00, -1, "sim_rr_b");
    ped_req = 2'b10;
    cyc(G1, 2'b10, 1, "sim_walk_entry");
    cycn(3, G1, 2'b10, 1, "sim_walk");
    cyc(G1, 2'b00, 1, "sim_walk_end");
    swing_back_to_g1("lat2");
    cyc(G1, 2'b00, 1, "sim_latch_cleared");
    cycn(4, G1, 2'b00, 1, "g1_rest2");

    // Reset during yellow, ped press while OFF ignored, restart
    car_req = 2'b01;
    cyc(Y1, 2'b00, 1, "pre_reset_y1");
    reset = 1'b1;
    cyc(OFF, 2'b00, 0, "reset_in_yellow");
    reset = 1'b0; car_req = 2'b00; ped_req = 2'b10;
    cycn(2, OFF, 2'b00, 0, "off_idle");
    start = 1'b1;
    cycn(2, RR, 2'b00, -1, "restart_allred");
    cycn(8, G0, 2'b00, 0, "off_ped_ignored");

    for (int i = 0; i < 4 && sb_q.size() != 0; i++) @(negedge clk);
    #1;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
